// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master side issues requests; the slave side computes.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             bit_valid;
    logic             serial_bit;
    logic             done;
    logic [WIDTH:0]   result;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, bit_valid, serial_bit, done, result, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, bit_valid, serial_bit, done, result, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder bit per clock, LSB first.
// Operands are loaded on start, and the result is loaded with a one-cycle done pulse.
//
// state   | meaning
// S_IDLE  | waiting for start; result/ovf hold the last answer
// S_SHIFT | one result bit per edge, WIDTH edges total
// S_DONE  | done pulse; result/ovf freshly valid
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    serial_addsub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] areg_q, areg_d;
    logic [WIDTH-1:0] breg_q, breg_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             carry_q, carry_d;
    logic             msub_q, msub_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             ovf_q, ovf_d;

    logic s_bit;
    logic c_next;
    logic last_bit;

    assign s_bit    = areg_q[0] ^ breg_q[0] ^ carry_q;
    assign c_next   = (areg_q[0] & breg_q[0]) | (areg_q[0] & carry_q) | (breg_q[0] & carry_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        areg_d   = areg_q;
        breg_d   = breg_q;
        sreg_d   = sreg_q;
        carry_d  = carry_q;
        msub_d   = msub_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    areg_d  = bus.a;
                    breg_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    msub_d  = bus.sub;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                carry_d = c_next;
                areg_d  = {1'b0, areg_q[WIDTH-1:1]};
                breg_d  = {1'b0, breg_q[WIDTH-1:1]};
                sreg_d  = {s_bit, sreg_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    // carry_q here is the carry into the MSB, so no separate flop is needed
                    result_d = {c_next ^ msub_q, s_bit, sreg_q[WIDTH-1:1]};
                    ovf_d    = carry_q ^ c_next;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            areg_q   <= '0;
            breg_q   <= '0;
            sreg_q   <= '0;
            carry_q  <= 1'b0;
            msub_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            areg_q   <= areg_d;
            breg_q   <= breg_d;
            sreg_q   <= sreg_d;
            carry_q  <= carry_d;
            msub_q   <= msub_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy       = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign bus.bit_valid  = (state_q == S_SHIFT);
    assign bus.serial_bit = (state_q == S_SHIFT) & s_bit;
    assign bus.done       = (state_q == S_DONE);
    assign bus.result     = result_q;
    assign bus.ovf        = ovf_q;
endmodule
